// File: rtl/pixel_rx_pkg.sv
// -----------------------------------------------------------------------------
// pixel_rx_pkg
// Shared types and constants for the pixel AXI4-Stream frame receiver.
//   rx_state_e    : framing FSM states
//   pix_meta_t    : per-pixel metadata at the default coordinate width
//   ERR_*         : bit positions in the sticky error vector
//   DIM_W_DEF     : default x/y counter width
// -----------------------------------------------------------------------------
package pixel_rx_pkg;

    localparam int unsigned DIM_W_DEF = 12;

    localparam int unsigned ERR_SOF_EARLY = 0;
    localparam int unsigned ERR_EOL_EARLY = 1;
    localparam int unsigned ERR_EOL_LATE  = 2;
    localparam int unsigned ERR_N         = 3;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic [DIM_W_DEF-1:0] x;
        logic [DIM_W_DEF-1:0] y;
        logic                 sof;
        logic                 eol;
    } pix_meta_t;

endpackage

// File: rtl/pixel_skid_buffer2.sv
// -----------------------------------------------------------------------------
// pixel_skid_buffer2
// Two-entry valid/ready buffer. Input ready is registered and depends only on
// occupancy, so it never combinationally follows s_valid_i. Head entry is held
// stable until it is popped.
//   clock, reset           : clock, synchronous active-high reset
//   s_valid_i/s_ready_o    : input handshake
//   s_data_i [W]           : input payload
//   m_valid_o/m_ready_i    : output handshake
//   m_data_o [W]           : output payload
// -----------------------------------------------------------------------------
module pixel_skid_buffer2 #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [W-1:0] s_data_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         s_ready_q;
    logic         m_valid_q;
    logic         push;
    logic         pop;

    assign push = s_valid_i & s_ready_q;
    assign pop  = m_valid_q & m_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= s_data_i;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q     <= cnt_d;
            s_ready_q <= (cnt_d != 2'd2);
            m_valid_q <= (cnt_d != 2'd0);
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = mem_q[rd_q];

endmodule

// File: rtl/pixel_axis_frame_rx.sv
// -----------------------------------------------------------------------------
// pixel_axis_frame_rx
// AXI4-Stream video slave. Enforces frame structure (SOF on tuser, EOL on
// tlast) against runtime width/height, tags forwarded pixels with x/y and
// SOF/EOL, and buffers them through a 2-entry skid buffer. A stall watchdog
// raises block when the upstream sender is stuck behind our backpressure.
//   clock, reset                   : clock, synchronous active-high reset
//   cfg_width, cfg_height          : frame geometry, latched on each SOF beat
//   s_axis_*                       : input pixel stream (tuser=SOF, tlast=EOL)
//   m_pix_*                        : tagged output pixel stream
//   frame_done                     : pulse when a frame's last beat is accepted
//   err_clear                      : clears sticky errors and dropped_cnt
//   err_sof_early/eol_early/late   : sticky framing errors
//   dropped_cnt                    : saturating count of beats dropped pre-SOF
//   block                          : upstream stall indication
// -----------------------------------------------------------------------------
module pixel_axis_frame_rx
    import pixel_rx_pkg::*;
#(
    parameter int unsigned PIX_W       = 24,
    parameter int unsigned DIM_W       = DIM_W_DEF,
    parameter int unsigned STALL_LIMIT = 1024,
    parameter int unsigned STALL_W     = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [PIX_W-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic [PIX_W-1:0] m_pix_data,
    output logic [DIM_W-1:0] m_pix_x,
    output logic [DIM_W-1:0] m_pix_y,
    output logic             m_pix_sof,
    output logic             m_pix_eol,
    output logic             m_pix_valid,
    input  logic             m_pix_ready,
    output logic             frame_done,
    input  logic             err_clear,
    output logic             err_sof_early,
    output logic             err_eol_early,
    output logic             err_eol_late,
    output logic [15:0]      dropped_cnt,
    output logic             block
);

    localparam int unsigned PAY_W = PIX_W + 2 * DIM_W + 2;
    localparam logic [STALL_W-1:0] LIMIT_C = STALL_W'(STALL_LIMIT);

    rx_state_e        state_q;
    logic [DIM_W-1:0] x_q, y_q, w_q, h_q;
    logic [ERR_N-1:0] err_q, err_d;
    logic [15:0]      drop_q, drop_d, drop_base;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic             block_q;

    logic             in_ready;
    logic             accept;
    logic             fwd;
    logic             take;
    logic             drop;
    logic             stall;

    logic [DIM_W-1:0] cur_x, cur_y, cur_w, cur_h;
    logic             last_x;
    logic             line_end;
    logic             frame_end;

    logic [PAY_W-1:0] in_payload;
    logic [PAY_W-1:0] out_payload;

    assign accept = s_axis_tvalid & in_ready;
    // A tuser beat always starts a frame, whichever state we are in.
    assign fwd    = (state_q == ACTIVE) | s_axis_tuser;
    assign take   = accept & fwd;
    assign drop   = accept & ~fwd;
    assign stall  = s_axis_tvalid & ~in_ready;

    // Position/geometry the current beat is judged against: an SOF beat is
    // evaluated as (0,0) of a frame using the freshly presented geometry, so
    // SOF+tlast and W=1/H=1 fall out of the ordinary line-end logic.
    always_comb begin
        cur_x     = s_axis_tuser ? '0 : x_q;
        cur_y     = s_axis_tuser ? '0 : y_q;
        cur_w     = s_axis_tuser ? cfg_width  : w_q;
        cur_h     = s_axis_tuser ? cfg_height : h_q;
        last_x    = (cur_x == cur_w - DIM_W'(1));
        line_end  = last_x | s_axis_tlast;
        frame_end = line_end & (cur_y == cur_h - DIM_W'(1));
    end

    // New errors are OR'd after the clear so a coincident error survives.
    always_comb begin
        err_d = err_q & {ERR_N{~err_clear}};
        if (take) begin
            if ((state_q == ACTIVE) && s_axis_tuser) begin
                err_d[ERR_SOF_EARLY] = 1'b1;
            end
            if (s_axis_tlast && (cur_x < cur_w - DIM_W'(1))) begin
                err_d[ERR_EOL_EARLY] = 1'b1;
            end
            if (last_x && !s_axis_tlast) begin
                err_d[ERR_EOL_LATE] = 1'b1;
            end
        end
    end

    always_comb begin
        drop_base = err_clear ? '0 : drop_q;
        drop_d    = drop_base;
        if (drop && (drop_base != '1)) begin
            drop_d = drop_base + 16'd1;
        end
    end

    always_comb begin
        stall_d = '0;
        if (stall) begin
            stall_d = (stall_q == LIMIT_C) ? stall_q : stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_SOF;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            err_q   <= '0;
            drop_q  <= '0;
            stall_q <= '0;
            block_q <= 1'b0;
        end else begin
            err_q   <= err_d;
            drop_q  <= drop_d;
            stall_q <= stall_d;
            block_q <= stall & (stall_q == LIMIT_C);
            if (take) begin
                w_q <= cur_w;
                h_q <= cur_h;
                if (frame_end) begin
                    state_q <= WAIT_SOF;
                    x_q     <= '0;
                    y_q     <= '0;
                end else if (line_end) begin
                    state_q <= ACTIVE;
                    x_q     <= '0;
                    y_q     <= cur_y + DIM_W'(1);
                end else begin
                    state_q <= ACTIVE;
                    x_q     <= cur_x + DIM_W'(1);
                    y_q     <= cur_y;
                end
            end
        end
    end

    assign in_payload = {s_axis_tdata, cur_x, cur_y, s_axis_tuser, line_end};

    pixel_skid_buffer2 #(
        .W (PAY_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .s_valid_i (s_axis_tvalid & fwd),
        .s_ready_o (in_ready),
        .s_data_i  (in_payload),
        .m_valid_o (m_pix_valid),
        .m_ready_i (m_pix_ready),
        .m_data_o  (out_payload)
    );

    assign {m_pix_data, m_pix_x, m_pix_y, m_pix_sof, m_pix_eol} = out_payload;

    assign s_axis_tready = in_ready;
    assign frame_done    = take & frame_end;
    assign err_sof_early = err_q[ERR_SOF_EARLY];
    assign err_eol_early = err_q[ERR_EOL_EARLY];
    assign err_eol_late  = err_q[ERR_EOL_LATE];
    assign dropped_cnt   = drop_q;
    assign block         = block_q;

endmodule

// File: tb/tb_pixel_axis_frame_rx.sv
module tb_pixel_axis_frame_rx;
    import pixel_rx_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] cfg_width = 12'd4;
    logic [11:0] cfg_height = 12'd2;
    logic [23:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [23:0] m_pix_data;
    logic [11:0] m_pix_x;
    logic [11:0] m_pix_y;
    logic        m_pix_sof;
    logic        m_pix_eol;
    logic        m_pix_valid;
    logic        m_pix_ready = 1'b1;
    logic        frame_done;
    logic        err_clear = 1'b0;
    logic        err_sof_early;
    logic        err_eol_early;
    logic        err_eol_late;
    logic [15:0] dropped_cnt;
    logic        block;

    pixel_axis_frame_rx #(
        .PIX_W       (24),
        .DIM_W       (12),
        .STALL_LIMIT (8),
        .STALL_W     (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .m_pix_data    (m_pix_data),
        .m_pix_x       (m_pix_x),
        .m_pix_y       (m_pix_y),
        .m_pix_sof     (m_pix_sof),
        .m_pix_eol     (m_pix_eol),
        .m_pix_valid   (m_pix_valid),
        .m_pix_ready   (m_pix_ready),
        .frame_done    (frame_done),
        .err_clear     (err_clear),
        .err_sof_early (err_sof_early),
        .err_eol_early (err_eol_early),
        .err_eol_late  (err_eol_late),
        .dropped_cnt   (dropped_cnt),
        .block         (block)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] d;
        pix_meta_t   m;
        int unsigned cyc;
    } rec_t;

    rec_t        out_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned acc_cnt = 0;
    int unsigned fd_cnt = 0;
    int unsigned fd_beat = 0;
    int unsigned first_acc_cyc = 0;
    bit          first_seen = 0;
    bit          drv_done = 0;

    always @(posedge clock) cyc++;

    // Observe everything mid-cycle, away from the active edge.
    always @(negedge clock) begin
        rec_t r;
        if (s_axis_tvalid && s_axis_tready) begin
            acc_cnt++;
            if (!first_seen) begin
                first_seen    = 1;
                first_acc_cyc = cyc;
            end
        end
        if (frame_done) begin
            fd_cnt++;
            fd_beat = acc_cnt;
        end
        if (m_pix_valid && m_pix_ready) begin
            r.d   = m_pix_data;
            r.m   = '{x: m_pix_x, y: m_pix_y, sof: m_pix_sof, eol: m_pix_eol};
            r.cyc = cyc;
            out_q.push_back(r);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "global timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        out_q.delete();
        acc_cnt    = 0;
        fd_cnt     = 0;
        fd_beat    = 0;
        first_seen = 0;
    endtask

    // Presents one beat and holds it until accepted (bounded).
    task automatic send_beat(input logic [23:0] d, input logic u, input logic l);
        bit ok;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (s_axis_tready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clock);
        #1;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL beat_accept_timeout: data %h not accepted, required acceptance within 200 cycles", d);
        end
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame4x2(input logic [23:0] base);
        for (int i = 0; i < 8; i++) begin
            send_beat(base + 24'(i), i == 0, (i % 4) == 3);
        end
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        @(negedge clock);
        total++;
        if ({s_axis_tready, m_pix_valid, frame_done, err_sof_early, err_eol_early, err_eol_late, block} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {s_axis_tready, m_pix_valid, frame_done, err_sof_early, err_eol_early, err_eol_late, block});
        end
        total++;
        if ({m_pix_data, m_pix_x, m_pix_y, m_pix_sof, m_pix_eol, dropped_cnt} !== 66'b0) begin
            bad++;
            $display("FAIL reset_data: got %h required 0",
                     {m_pix_data, m_pix_x, m_pix_y, m_pix_sof, m_pix_eol, dropped_cnt});
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_clean_frame();
        logic [49:0] want;
        clear_mon();
        cfg_width = 12'd4; cfg_height = 12'd2; m_pix_ready = 1'b1;
        send_frame4x2(24'h00A000);
        step(3);
        total++;
        if (out_q.size() !== 8) begin
            bad++;
            $display("FAIL clean_count: got %0d required 8", out_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                want = {24'h00A000 + 24'(i), 12'(i % 4), 12'(i / 4), 1'(i == 0), 1'((i % 4) == 3)};
                total++;
                if ({out_q[i].d, out_q[i].m} !== want) begin
                    bad++;
                    $display("FAIL clean_pix%0d: got %h required %h", i, {out_q[i].d, out_q[i].m}, want);
                end
            end
            total++;
            if (out_q[0].cyc !== first_acc_cyc + 1) begin
                bad++;
                $display("FAIL clean_latency: got cycle %0d required %0d", out_q[0].cyc, first_acc_cyc + 1);
            end
            total++;
            if (out_q[7].cyc - out_q[0].cyc !== 7) begin
                bad++;
                $display("FAIL clean_throughput: got span %0d required 7", out_q[7].cyc - out_q[0].cyc);
            end
        end
        total++;
        if (fd_cnt !== 1 || fd_beat !== 8) begin
            bad++;
            $display("FAIL clean_frame_done: got count %0d at beat %0d required 1 at beat 8", fd_cnt, fd_beat);
        end
        total++;
        if ({err_sof_early, err_eol_early, err_eol_late} !== 3'b000) begin
            bad++;
            $display("FAIL clean_errors: got %b required 000", {err_sof_early, err_eol_early, err_eol_late});
        end
    endtask

    task automatic test_drop();
        clear_mon();
        for (int i = 1; i <= 3; i++) send_beat(24'(i), 1'b0, 1'b0);
        idle();
        step(2);
        total++;
        if (out_q.size() !== 0 || dropped_cnt !== 16'd3) begin
            bad++;
            $display("FAIL drop_count: got outputs %0d dropped %0d required 0 and 3", out_q.size(), dropped_cnt);
        end
        send_frame4x2(24'h00B000);
        step(3);
        total++;
        if (out_q.size() !== 8 || {out_q[0].d, out_q[0].m} !== {24'h00B000, 12'd0, 12'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL drop_first_pix: got %0d outputs first %h required 8 outputs first %h", out_q.size(),
                     {out_q[0].d, out_q[0].m}, {24'h00B000, 12'd0, 12'd0, 1'b1, 1'b0});
        end
        total++;
        if (fd_cnt !== 1) begin
            bad++;
            $display("FAIL drop_frame_done: got %0d required 1", fd_cnt);
        end
    endtask

    task automatic test_eol_early();
        clear_mon();
        send_beat(24'h00C000, 1'b1, 1'b0);
        send_beat(24'h00C001, 1'b0, 1'b1);
        send_beat(24'h00C002, 1'b0, 1'b0);
        send_beat(24'h00C003, 1'b0, 1'b0);
        send_beat(24'h00C004, 1'b0, 1'b0);
        send_beat(24'h00C005, 1'b0, 1'b1);
        idle();
        step(3);
        total++;
        if ({err_sof_early, err_eol_early, err_eol_late} !== 3'b010) begin
            bad++;
            $display("FAIL eol_early_flags: got %b required 010", {err_sof_early, err_eol_early, err_eol_late});
        end
        total++;
        if (out_q.size() !== 6) begin
            bad++;
            $display("FAIL eol_early_count: got %0d required 6", out_q.size());
        end else begin
            total++;
            if ({out_q[1].d, out_q[1].m} !== {24'h00C001, 12'd1, 12'd0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL eol_early_pix1: got %h required %h", {out_q[1].d, out_q[1].m},
                         {24'h00C001, 12'd1, 12'd0, 1'b0, 1'b1});
            end
            total++;
            if ({out_q[2].d, out_q[2].m} !== {24'h00C002, 12'd0, 12'd1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL eol_early_pix2: got %h required %h", {out_q[2].d, out_q[2].m},
                         {24'h00C002, 12'd0, 12'd1, 1'b0, 1'b0});
            end
            total++;
            if ({out_q[5].d, out_q[5].m} !== {24'h00C005, 12'd3, 12'd1, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL eol_early_pix5: got %h required %h", {out_q[5].d, out_q[5].m},
                         {24'h00C005, 12'd3, 12'd1, 1'b0, 1'b1});
            end
        end
        total++;
        if (fd_cnt !== 1 || fd_beat !== 6) begin
            bad++;
            $display("FAIL eol_early_frame_done: got count %0d at beat %0d required 1 at beat 6", fd_cnt, fd_beat);
        end
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
    endtask

    task automatic test_sof_early();
        clear_mon();
        send_beat(24'h00D000, 1'b1, 1'b0);
        send_beat(24'h00D001, 1'b0, 1'b0);
        send_beat(24'h00D002, 1'b1, 1'b0);
        send_beat(24'h00D003, 1'b0, 1'b0);
        send_beat(24'h00D004, 1'b0, 1'b0);
        send_beat(24'h00D005, 1'b0, 1'b1);
        for (int i = 6; i < 10; i++) send_beat(24'h00D000 + 24'(i), 1'b0, i == 9);
        idle();
        step(3);
        total++;
        if ({err_sof_early, err_eol_early, err_eol_late} !== 3'b100) begin
            bad++;
            $display("FAIL sof_early_flags: got %b required 100", {err_sof_early, err_eol_early, err_eol_late});
        end
        total++;
        if (out_q.size() !== 10) begin
            bad++;
            $display("FAIL sof_early_count: got %0d required 10", out_q.size());
        end else begin
            total++;
            if ({out_q[2].d, out_q[2].m} !== {24'h00D002, 12'd0, 12'd0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL sof_early_restart: got %h required %h", {out_q[2].d, out_q[2].m},
                         {24'h00D002, 12'd0, 12'd0, 1'b1, 1'b0});
            end
            total++;
            if ({out_q[3].d, out_q[3].m} !== {24'h00D003, 12'd1, 12'd0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL sof_early_next: got %h required %h", {out_q[3].d, out_q[3].m},
                         {24'h00D003, 12'd1, 12'd0, 1'b0, 1'b0});
            end
            total++;
            if ({out_q[9].d, out_q[9].m} !== {24'h00D009, 12'd3, 12'd1, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL sof_early_last: got %h required %h", {out_q[9].d, out_q[9].m},
                         {24'h00D009, 12'd3, 12'd1, 1'b0, 1'b1});
            end
        end
        total++;
        if (fd_cnt !== 1 || fd_beat !== 10) begin
            bad++;
            $display("FAIL sof_early_frame_done: got count %0d at beat %0d required 1 at beat 10", fd_cnt, fd_beat);
        end
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        @(negedge clock);
        total++;
        if ({err_sof_early, err_eol_early, err_eol_late} !== 3'b000 || dropped_cnt !== 16'd0) begin
            bad++;
            $display("FAIL err_clear: got flags %b dropped %0d required 000 and 0",
                     {err_sof_early, err_eol_early, err_eol_late}, dropped_cnt);
        end
        step(1);
    endtask

    task automatic test_eol_late_and_clear_race();
        clear_mon();
        cfg_width = 12'd2; cfg_height = 12'd1;
        send_beat(24'h00E000, 1'b1, 1'b0);
        send_beat(24'h00E001, 1'b0, 1'b0);
        idle();
        step(3);
        total++;
        if ({err_sof_early, err_eol_early, err_eol_late} !== 3'b001 || fd_cnt !== 1) begin
            bad++;
            $display("FAIL eol_late: got flags %b frame_done %0d required 001 and 1",
                     {err_sof_early, err_eol_early, err_eol_late}, fd_cnt);
        end
        total++;
        if (out_q.size() !== 2 || {out_q[1].d, out_q[1].m} !== {24'h00E001, 12'd1, 12'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL eol_late_pix: got %0d outputs last %h required 2 outputs last %h", out_q.size(),
                     {out_q[1].d, out_q[1].m}, {24'h00E001, 12'd1, 12'd0, 1'b0, 1'b1});
        end
        // SOF+tlast at W=2: early EOL in the same cycle as err_clear.
        err_clear = 1'b1;
        send_beat(24'h00E002, 1'b1, 1'b1);
        err_clear = 1'b0;
        idle();
        step(2);
        total++;
        if ({err_sof_early, err_eol_early, err_eol_late} !== 3'b010 || fd_cnt !== 2) begin
            bad++;
            $display("FAIL clear_race: got flags %b frame_done %0d required 010 and 2",
                     {err_sof_early, err_eol_early, err_eol_late}, fd_cnt);
        end
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
    endtask

    task automatic test_w1_h1();
        clear_mon();
        cfg_width = 12'd1; cfg_height = 12'd1;
        send_beat(24'h00F100, 1'b1, 1'b1);
        send_beat(24'h00F101, 1'b1, 1'b1);
        idle();
        step(3);
        total++;
        if (fd_cnt !== 2 || out_q.size() !== 2) begin
            bad++;
            $display("FAIL w1_frames: got frame_done %0d outputs %0d required 2 and 2", fd_cnt, out_q.size());
        end else begin
            total++;
            if ({out_q[0].d, out_q[0].m, out_q[1].d, out_q[1].m} !==
                {24'h00F100, 12'd0, 12'd0, 1'b1, 1'b1, 24'h00F101, 12'd0, 12'd0, 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL w1_pix: got %h %h required %h %h", {out_q[0].d, out_q[0].m}, {out_q[1].d, out_q[1].m},
                         {24'h00F100, 12'd0, 12'd0, 1'b1, 1'b1}, {24'h00F101, 12'd0, 12'd0, 1'b1, 1'b1});
            end
        end
        total++;
        if ({err_sof_early, err_eol_early, err_eol_late} !== 3'b000) begin
            bad++;
            $display("FAIL w1_errors: got %b required 000", {err_sof_early, err_eol_early, err_eol_late});
        end
    endtask

    task automatic test_stall();
        bit          dropped_block;
        logic [49:0] want;
        clear_mon();
        cfg_width = 12'd4; cfg_height = 12'd2;
        m_pix_ready = 1'b0;
        drv_done = 0;
        fork
            begin
                send_frame4x2(24'h001000);
                drv_done = 1;
            end
        join_none
        repeat (6) @(negedge clock);
        total++;
        if (acc_cnt !== 2 || s_axis_tready !== 1'b0 || block !== 1'b0) begin
            bad++;
            $display("FAIL stall_fill: got accepted %0d tready %b block %b required 2 0 0", acc_cnt, s_axis_tready, block);
        end
        total++;
        if (m_pix_valid !== 1'b1 || m_pix_data !== 24'h001000) begin
            bad++;
            $display("FAIL stall_hold: got valid %b data %h required 1 001000", m_pix_valid, m_pix_data);
        end
        repeat (8) @(negedge clock);
        total++;
        if (block !== 1'b1) begin
            bad++;
            $display("FAIL stall_block: got %b required 1", block);
        end
        @(posedge clock);
        #1;
        m_pix_ready = 1'b1;
        dropped_block = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (block === 1'b0) begin
                dropped_block = 1;
                break;
            end
        end
        total++;
        if (!dropped_block) begin
            bad++;
            $display("FAIL stall_release: block still %b, required 0 within 2 cycles", block);
        end
        for (int i = 0; i < 100 && !drv_done; i++) @(negedge clock);
        total++;
        if (!drv_done) begin
            bad++;
            $display("FAIL stall_drain_timeout: driver done %b required 1", drv_done);
        end
        step(3);
        total++;
        if (out_q.size() !== 8) begin
            bad++;
            $display("FAIL stall_count: got %0d required 8", out_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                want = {24'h001000 + 24'(i), 12'(i % 4), 12'(i / 4), 1'(i == 0), 1'((i % 4) == 3)};
                total++;
                if ({out_q[i].d, out_q[i].m} !== want) begin
                    bad++;
                    $display("FAIL stall_pix%0d: got %h required %h", i, {out_q[i].d, out_q[i].m}, want);
                end
            end
        end
        total++;
        if (fd_cnt !== 1) begin
            bad++;
            $display("FAIL stall_frame_done: got %0d required 1", fd_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        cfg_width = 12'd4; cfg_height = 12'd2;
        for (int i = 0; i < 6; i++) send_beat(24'h002000 + 24'(i), i == 0, i == 3);
        idle();
        reset = 1'b1;
        step(2);
        @(negedge clock);
        total++;
        if ({s_axis_tready, m_pix_valid, frame_done, err_sof_early, err_eol_early, err_eol_late, block} !== 7'b0 ||
            {m_pix_data, m_pix_x, m_pix_y, m_pix_sof, m_pix_eol, dropped_cnt} !== 66'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got %b %h required all 0",
                     {s_axis_tready, m_pix_valid, frame_done, err_sof_early, err_eol_early, err_eol_late, block},
                     {m_pix_data, m_pix_x, m_pix_y, m_pix_sof, m_pix_eol, dropped_cnt});
        end
        total++;
        if (fd_cnt !== 0) begin
            bad++;
            $display("FAIL midreset_frame_done: got %0d required 0", fd_cnt);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_mon();
        send_beat(24'h002010, 1'b0, 1'b0);
        send_beat(24'h002011, 1'b0, 1'b0);
        idle();
        step(2);
        total++;
        if (dropped_cnt !== 16'd2 || out_q.size() !== 0) begin
            bad++;
            $display("FAIL midreset_drop: got dropped %0d outputs %0d required 2 and 0", dropped_cnt, out_q.size());
        end
        send_frame4x2(24'h003000);
        step(3);
        total++;
        if (out_q.size() !== 8 || {out_q[0].d, out_q[0].m} !== {24'h003000, 12'd0, 12'd0, 1'b1, 1'b0} ||
            fd_cnt !== 1) begin
            bad++;
            $display("FAIL midreset_restart: got %0d outputs first %h frame_done %0d required 8 %h 1", out_q.size(),
                     {out_q[0].d, out_q[0].m}, {24'h003000, 12'd0, 12'd0, 1'b1, 1'b0}, fd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_drop();
        test_eol_early();
        test_sof_early();
        test_eol_late_and_clear_race();
        test_w1_h1();
        test_stall();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
